// File: rtl/data_mem_resp.sv
// Data-memory responder for the M/WB data port: one-cycle registered reads, byte-lane
// partial stores, a zero-clear sweep after reset and a valid/ready word loader.
module data_mem_resp #(
    parameter int AW             = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          Clock,
    input  logic          nReset,
    input  logic [15:0]   MemAddr,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic          WriteL,
    input  logic          WriteR,
    input  logic [31:0]   WriteData,
    output logic [31:0]   MemData,
    output logic          Ready,
    input  logic          LdValid,
    output logic          LdReady,
    input  logic [AW-1:0] LdAddr,
    input  logic [31:0]   LdData,
    output logic          AddrErr
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {S_INIT, S_RUN} state_t;
    localparam state_t RST_STATE = CLEAR_ON_RESET ? S_INIT : S_RUN;

    state_t        state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic [31:0]   mem_data_q, mem_data_d;
    logic          addr_err_q, addr_err_d;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx;
    logic [1:0]    ofs;
    logic          oor;
    logic [3:0]    lane_en;
    logic          wr_err;
    logic          ld_ready;

    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic [3:0]    wbe;

    assign idx = MemAddr[AW+1:2];
    assign ofs = MemAddr[1:0];
    // Any address bit above the word-index field means the access misses the array.
    assign oor = |(MemAddr >> (AW + 2));

    always_comb begin
        lane_en = 4'hF;
        for (int i = 0; i < 4; i++) begin
            unique case ({WriteL, WriteR})
                2'b10:   lane_en[i] = (2'(i) >= ofs);
                2'b01:   lane_en[i] = (2'(i) <= ofs);
                default: lane_en[i] = 1'b1;
            endcase
        end
    end

    assign wr_err   = oor | (WriteL & WriteR) | (~WriteL & ~WriteR & (ofs != 2'd0));
    assign ld_ready = (state_q == S_RUN) & ~MemWrite;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        mem_data_d = mem_data_q;
        addr_err_d = addr_err_q;
        we         = 1'b0;
        waddr      = init_cnt_q;
        wdata      = '0;
        wbe        = 4'h0;

        unique case (state_q)
            S_INIT: begin
                we         = 1'b1;
                wbe        = 4'hF;
                init_cnt_d = init_cnt_q + 1'b1;
                if (&init_cnt_q) state_d = S_RUN;
            end
            default: begin
                // Read samples the array before this edge's write lands: read-first.
                if (MemRead) begin
                    if (oor) begin
                        mem_data_d = '0;
                        addr_err_d = 1'b1;
                    end else begin
                        mem_data_d = mem[idx];
                    end
                end
                if (MemWrite) begin
                    if (wr_err) begin
                        addr_err_d = 1'b1;
                    end else begin
                        we    = 1'b1;
                        waddr = idx;
                        wdata = WriteData;
                        wbe   = lane_en;
                    end
                end else if (LdValid) begin
                    we    = 1'b1;
                    waddr = LdAddr;
                    wdata = LdData;
                    wbe   = 4'hF;
                end
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= RST_STATE;
            init_cnt_q <= '0;
            mem_data_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            mem_data_q <= mem_data_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign MemData = mem_data_q;
    assign Ready   = (state_q == S_RUN);
    assign LdReady = ld_ready;
    assign AddrErr = addr_err_q;

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
Data-memory responder for the pipelined processor's M/WB data port. Accepts the processor's MemAddr/MemRead/MemWrite/WriteL/WriteR/WriteData and returns MemData one cycle later, so that data lands in the WB stage. Backed by a synchronous word array that is zero-cleared after reset by an init FSM. A secondary loader port lets the bench or boot logic preload words with a valid/ready handshake.

Parameters:
AW, 10, word-address width; the array holds 2**AW 32-bit words, and the byte-address span is 2**(AW+2).
CLEAR_ON_RESET, 1, 1 means run the INIT clear sweep after reset; 0 means enter RUN directly and leave array contents undefined.

Ports:
Clock      in   1   system clock, rising edge
nReset     in   1   asynchronous active-low reset
MemAddr    in   16  byte address from the processor M stage
MemRead    in   1   read request
MemWrite   in   1   write request
WriteL     in   1   partial-left store (SWL-type)
WriteR     in   1   partial-right store (SWR-type)
WriteData  in   32  lane-aligned store data
MemData    out  32  registered read data, consumed in WB
Ready      out  1   high in RUN state
LdValid    in   1   loader word valid
LdReady    out  1   loader accept
LdAddr     in   AW  loader word address
LdData     in   32  loader word
AddrErr    out  1   sticky error flag, cleared only by reset

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low. All flops use nReset.
- Reset values: MemData=0, Ready=0 (Ready=1 if CLEAR_ON_RESET=0), LdReady=0, AddrErr=0, InitCnt=0, state=INIT (RUN if CLEAR_ON_RESET=0).
- FSM INIT:
  - Writes 0 to word InitCnt each cycle, then InitCnt++.
  - When InitCnt==2**AW-1 is written, go to RUN on the next edge. Total INIT time is exactly 2**AW cycles.
  - Processor and loader requests are ignored: no write, MemData held at 0, AddrErr unchanged.
- FSM RUN: stays in RUN until reset. Reset asserted mid-sweep or mid-run returns to INIT and restarts at InitCnt=0.
- Address decode:
  - Word index = MemAddr[AW+1:2]; offset o = MemAddr[1:0].
  - Out of range means MemAddr[15:AW+2] != 0 (only possible when AW<14).
- Processor write (RUN, MemWrite=1), byte-lane enables with lane 0 = bits 7:0:
  - WriteL=0, WriteR=0: full word, all lanes. Requires o==0; if o!=0 the write is dropped and AddrErr is set.
  - WriteL=1, WriteR=0: lanes o..3 written from the same lanes of WriteData. Other lanes are kept.
  - WriteL=0, WriteR=1: lanes 0..o written. Other lanes are kept.
  - WriteL=1, WriteR=1: illegal. Write is dropped and AddrErr is set.
  - Out-of-range write: dropped, AddrErr set.
- Processor read (RUN, MemRead=1):
  - MemData <= array[index] at the next edge, so latency is 1 cycle.
  - Out-of-range read: MemData <= 0 and AddrErr is set.
  - When MemRead=0, MemData holds its previous value.
- Simultaneous MemRead and MemWrite to the same word in one cycle: read-first, so MemData returns the old word and the array takes the new one.
- Write in cycle N followed by a read of the same word in N+1 returns the written data (no forwarding needed).
- Loader:
  - LdReady = (state==RUN) & ~MemWrite. The processor write has priority.
  - A transfer occurs when LdValid & LdReady; the full word LdData is written to array[LdAddr].
  - LdValid/LdAddr/LdData must hold until accepted.
  - A loader transfer never alters MemData.
- Single write port: at most one array write per cycle, priority INIT clear > processor write > loader.

Test Plan:
- Reset then idle, AW=4: Ready=0 for exactly 16 cycles, then 1. Reads of byte addresses 0x0000..0x003C all return 0x00000000. AddrErr=0.
- Full word write 0xDEADBEEF @0x0010, then read @0x0010 next cycle -> MemData=0xDEADBEEF one cycle after MemRead.
- Word 0x0010 = 0x11223344; WriteL with MemAddr=0x0012, WriteData=0xAABBCCDD -> word reads 0xAABB3344. Then WriteR with MemAddr=0x0011, WriteData=0x55667788 -> word reads 0xAABB7788.
- Same-cycle MemRead+MemWrite 0x12345678 @0x0020 holding 0x0 -> MemData=0x00000000. Following read -> 0x12345678.
- Loader: LdValid=1, LdAddr=3, LdData=0xCAFEF00D while MemWrite=1 -> LdReady=0 and no transfer. MemWrite drops -> accepted. Processor read @0x000C -> 0xCAFEF00D.
- Error and reset cases:
  - Full write @0x0002 -> dropped, AddrErr=1.
  - With AW=4, read @0x0100 -> MemData=0, AddrErr stays 1.
  - Assert nReset=0 mid-INIT at InitCnt=7 -> all outputs return to reset values at once. After release, Ready rises after 16 cycles.
